// File: rtl/stat_pkg.sv
// Shared types and defaults for the output statistics collector.
package stat_pkg;

  localparam int NUM_OUT_DEF = 22;
  localparam int CNT_W_DEF   = 16;
  localparam int IDX_W_DEF   = $clog2(NUM_OUT_DEF);

  // Run phases: idle, counting responses, streaming counts, finished.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/output_stat_collector_if.sv
// Response input and count readout port of the collector.
// master = environment side, slave = collector side.
interface output_stat_collector_if
  import stat_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IDX_W   = $clog2(NUM_OUT)
);
  logic               resp_valid;
  logic [NUM_OUT-1:0] resp_data;
  logic               rd_valid;
  logic               rd_ready;
  logic [IDX_W-1:0]   rd_index;
  logic [CNT_W-1:0]   rd_count;
  logic               rd_last;

  modport master (
    output resp_valid, resp_data, rd_ready,
    input  rd_valid, rd_index, rd_count, rd_last
  );

  modport slave (
    input  resp_valid, resp_data, rd_ready,
    output rd_valid, rd_index, rd_count, rd_last
  );
endinterface

// File: rtl/stat_bit_counter.sv
// Ones counter for a single observed output bit.
module stat_bit_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; the run logic never asserts both.
  always_ff @(posedge clk) begin
    if (reset)           count <= '0;
    else if (clear)      count <= '0;
    else if (en && inc)  count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/output_stat_collector.sv
// Per-bit ones counting over a programmed number of response patterns,
// followed by an in-order valid/ready readout of all per-bit counts.
module output_stat_collector
  import stat_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IDX_W   = $clog2(NUM_OUT)
) (
  input  logic                        v_in1_v,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CNT_W-1:0]            num_patterns,
  output_stat_collector_if.slave      bus,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            pat_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               target_q;
  logic [IDX_W-1:0]               idx_q;
  logic [NUM_OUT-1:0][CNT_W-1:0]  cnt;

  logic start_ok;
  logic acc;
  logic rd_fire;
  logic last_pat;

  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign acc      = (state_q == ACCUM) && bus.resp_valid;
  assign rd_fire  = (state_q == DRAIN) && bus.rd_ready;
  assign last_pat = (pat_count + CNT_W'(1)) == target_q;

  // State register.
  always_ff @(posedge v_in1_v) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: an ACCUM run ends on the pattern that reaches the target,
  // so DRAIN starts the very next cycle with that pattern already counted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (num_patterns == '0) ? DRAIN : ACCUM;
      ACCUM:      if (acc && last_pat) state_d = DRAIN;
      DRAIN:      if (rd_fire && idx_q == LAST_IDX) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Target and accepted-pattern count; both reset on every accepted start.
  always_ff @(posedge v_in1_v) begin
    if (reset) begin
      target_q  <= '0;
      pat_count <= '0;
    end else if (start_ok) begin
      target_q  <= num_patterns;
      pat_count <= '0;
    end else if (acc) begin
      pat_count <= pat_count + CNT_W'(1);
    end
  end

  // Readout index walks 0..NUM_OUT-1 once per drain, then rewinds.
  always_ff @(posedge v_in1_v) begin
    if (reset)         idx_q <= '0;
    else if (start_ok) idx_q <= '0;
    else if (rd_fire)  idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_bit
    stat_bit_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (v_in1_v),
      .reset (reset),
      .clear (start_ok),
      .en    (acc),
      .inc   (bus.resp_data[i]),
      .count (cnt[i])
    );
  end

  assign busy         = (state_q == ACCUM) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign bus.rd_valid = (state_q == DRAIN);
  assign bus.rd_index = idx_q;
  assign bus.rd_count = (state_q == DRAIN) ? cnt[idx_q] : '0;
  assign bus.rd_last  = (state_q == DRAIN) && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_output_stat_collector.sv
// Randomized bench for output_stat_collector with a behavioural run model.
module tb_output_stat_collector;
  localparam int NO = 22;
  localparam int CW = 16;
  localparam int IW = 5;

  logic          v_in1_v = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_patterns = '0;
  logic          busy, done;
  logic [CW-1:0] pat_count;

  output_stat_collector_if #(.NUM_OUT(NO), .CNT_W(CW), .IDX_W(IW)) bus ();

  output_stat_collector #(.NUM_OUT(NO), .CNT_W(CW), .IDX_W(IW)) dut (
    .v_in1_v      (v_in1_v),
    .reset        (reset),
    .start        (start),
    .num_patterns (num_patterns),
    .bus          (bus.slave),
    .busy         (busy),
    .done         (done),
    .pat_count    (pat_count)
  );

  always #5 v_in1_v = ~v_in1_v;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 collecting, 2 reading out, 3 finished.
  int ph = 0;
  int m_cnt[NO];
  int m_pat = 0, m_tgt = 0, m_idx = 0;
  int cyc = 0;

  always @(posedge v_in1_v) begin
    cyc++;
    if (reset) begin
      ph = 0; m_pat = 0; m_tgt = 0; m_idx = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      case (ph)
        0, 3: if (start) begin
          foreach (m_cnt[i]) m_cnt[i] = 0;
          m_pat = 0; m_idx = 0; m_tgt = int'(num_patterns);
          ph = (m_tgt == 0) ? 2 : 1;
        end
        1: if (bus.resp_valid) begin
          m_pat++;
          for (int i = 0; i < NO; i++) m_cnt[i] += int'(bus.resp_data[i]);
          if (m_pat == m_tgt) ph = 2;
        end
        2: if (bus.rd_ready) begin
          if (m_idx == NO - 1) begin ph = 3; m_idx = 0; end
          else m_idx++;
        end
        default: ;
      endcase
    end
  end

  // Per-word delivery record, filled from the DUT readout as words are taken.
  int got[NO];
  int seen[NO];

  always @(negedge v_in1_v) begin
    if (cyc > 0) begin
      chk("busy", 32'(busy), 32'(ph == 1 || ph == 2));
      chk("done", 32'(done), 32'(ph == 3));
      chk("rd_valid", 32'(bus.rd_valid), 32'(ph == 2));
      chk("pat_count", 32'(pat_count), 32'(m_pat));
      if (ph == 2) begin
        chk("rd_index", 32'(bus.rd_index), 32'(m_idx));
        chk("rd_count", 32'(bus.rd_count), 32'(m_cnt[m_idx]));
        chk("rd_last", 32'(bus.rd_last), 32'(m_idx == NO - 1));
        if (bus.rd_ready && bus.rd_index < IW'(NO)) begin
          got[bus.rd_index]  = int'(bus.rd_count);
          seen[bus.rd_index] = seen[bus.rd_index] + 1;
        end
      end else begin
        chk("rd_last_idle", 32'(bus.rd_last), 32'd0);
      end
    end
  end

  task automatic tick;
    @(posedge v_in1_v);
    #1;
  endtask

  task automatic clear_got;
    for (int i = 0; i < NO; i++) begin got[i] = -1; seen[i] = 0; end
  endtask

  task automatic check_seen;
    for (int i = 0; i < NO; i++) chk("seen_once", 32'(seen[i]), 32'd1);
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_patterns = CW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready, input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      bus.rd_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
      tick();
      n++;
    end
    chk("done_within_budget", 32'(done), 32'd1);
    bus.rd_ready = 1'b1;
  endtask

  task automatic check_reset_outputs;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_index", 32'(bus.rd_index), 32'd0);
    chk("rst_rd_count", 32'(bus.rd_count), 32'd0);
    chk("rst_rd_last", 32'(bus.rd_last), 32'd0);
    chk("rst_pat_count", 32'(pat_count), 32'd0);
  endtask

  logic [NO-1:0] t1_data [4];
  logic [NO-1:0] w3 [3];

  initial begin
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    bus.rd_ready   = 1'b1;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    clear_got();

    // Basic run of four patterns.
    tick(); tick();
    reset = 1'b0;
    check_reset_outputs();
    t1_data[0] = 22'h000001; t1_data[1] = 22'h000003;
    t1_data[2] = 22'h200001; t1_data[3] = 22'h000000;
    do_start(4);
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus.resp_valid = 1'b1;
      bus.resp_data  = t1_data[k];
      tick();
    end
    bus.resp_valid = 1'b0;
    chk("t1_drain_now", 32'(bus.rd_valid), 32'd1);
    chk("t1_first_idx", 32'(bus.rd_index), 32'd0);
    chk("t1_first_cnt", 32'(bus.rd_count), 32'd3);
    wait_done(1'b0, 60);
    chk("t1_idx0", 32'(got[0]), 32'd3);
    chk("t1_idx1", 32'(got[1]), 32'd1);
    chk("t1_idx21", 32'(got[21]), 32'd1);
    for (int i = 2; i < 21; i++) chk("t1_other", 32'(got[i]), 32'd0);
    chk("t1_pat_count", 32'(pat_count), 32'd4);
    check_seen();

    // Zero-pattern run goes straight to readout.
    clear_got();
    do_start(0);
    chk("t2_drain_next", 32'(bus.rd_valid), 32'd1);
    begin
      int n = 0;
      while (!done && n < 40) begin tick(); n++; end
      chk("t2_drain_len", 32'(n), 32'(NO));
    end
    for (int i = 0; i < NO; i++) chk("t2_zero", 32'(got[i]), 32'd0);
    check_seen();

    // Responses outside ACCUM are ignored; gaps between patterns; stalled readout.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.resp_valid = 1'b1;
      bus.resp_data  = NO'($urandom);
      tick();
    end
    clear_got();
    for (int k = 0; k < 3; k++) w3[k] = NO'($urandom);
    bus.resp_data = '1;
    do_start(3);
    bus.resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      bus.resp_valid = 1'b1;
      bus.resp_data  = w3[k];
      tick();
      bus.resp_valid = 1'b0;
      bus.resp_data  = NO'($urandom);
    end
    chk("t3_drain_after_third", 32'(bus.rd_valid), 32'd1);
    wait_done(1'b1, 400);
    for (int i = 0; i < NO; i++)
      chk("t3_count", 32'(got[i]), 32'(int'(w3[0][i]) + int'(w3[1][i]) + int'(w3[2][i])));
    check_seen();

    // Full-scale run: no wrap at the top of the counter range.
    clear_got();
    do_start(65535);
    bus.resp_valid = 1'b1;
    bus.resp_data  = '1;
    for (int k = 0; k < 65535; k++) tick();
    bus.resp_valid = 1'b0;
    chk("t5_pat_max", 32'(pat_count), 32'd65535);
    wait_done(1'b0, 60);
    for (int i = 0; i < NO; i++) chk("t5_full", 32'(got[i]), 32'd65535);

    // Restart from DONE with a coincident response: start wins, response dropped.
    clear_got();
    bus.resp_valid = 1'b1;
    bus.resp_data  = '1;
    do_start(2);
    chk("t5b_pat_cleared", 32'(pat_count), 32'd0);
    chk("t5b_busy", 32'(busy), 32'd1);
    bus.resp_data = '0;
    tick(); tick();
    bus.resp_valid = 1'b0;
    wait_done(1'b0, 60);
    for (int i = 0; i < NO; i++) chk("t5b_cleared", 32'(got[i]), 32'd0);

    // Reset in the middle of a run discards it.
    do_start(5);
    bus.resp_valid = 1'b1;
    bus.resp_data  = NO'($urandom);
    tick(); tick();
    bus.resp_valid = 1'b0;
    chk("t6_partial", 32'(pat_count), 32'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_outputs();
    clear_got();
    do_start(1);
    bus.resp_valid = 1'b1;
    bus.resp_data  = 22'h3FFFFF;
    tick();
    bus.resp_valid = 1'b0;
    wait_done(1'b0, 60);
    for (int i = 0; i < NO; i++) chk("t6_ones", 32'(got[i]), 32'd1);

    // Random runs with noise on start, valid and ready.
    for (int r = 0; r < 6; r++) begin
      int n = 0;
      clear_got();
      do_start($urandom_range(1, 12));
      while (ph == 1 && n < 500) begin
        bus.resp_valid = 1'($urandom % 2);
        bus.resp_data  = NO'($urandom);
        start          = 1'($urandom % 4 == 0);
        num_patterns   = CW'($urandom);
        tick();
        n++;
      end
      bus.resp_valid = 1'b0;
      start = 1'b0;
      chk("rand_accum_ended", 32'(ph), 32'd2);
      wait_done(1'b1, 400);
      check_seen();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_stat_collector.md
# output_stat_collector

Synthesizable response-side companion to the locked-circuit stimulus driver in the statistical-attack flow. Accepts the 22-bit primary-output word of the locked circuit once per applied pattern and counts, per output bit, how many patterns produced a 1 over a programmed number of patterns. It then streams the 22 per-bit counts out over a valid/ready port for the key-guess scoring logic.

## Interface
Parameters:
- NUM_OUT, 22, number of circuit outputs observed (o1..o22).
- CNT_W, 16, width of pattern target and of each per-bit counter.
- IDX_W, $clog2(NUM_OUT) (5), width of readout index.

Ports (clock and reset first):
- v_in1_v  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- num_patterns  in  CNT_W  patterns to accumulate; latched on accepted start.
- resp_valid  in  1  resp_data holds one pattern's response this cycle.
- resp_data  in  NUM_OUT  output word; bit 0 = o1, bit NUM_OUT-1 = o22.
- busy  out  1  high in ACCUM or DRAIN.
- done  out  1  high in DONE.
- rd_valid  out  1  readout word valid.
- rd_ready  in  1  consumer accepts readout word.
- rd_index  out  IDX_W  output-bit index of current word (0 = o1).
- rd_count  out  CNT_W  ones count for that bit.
- rd_last  out  1  high with index NUM_OUT-1.
- pat_count  out  CNT_W  patterns accepted in current run.

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE/DONE + start: clear all counters and pat_count; latch num_patterns as target. If target == 0, go to DRAIN; else go to ACCUM.
- ACCUM: each cycle with resp_valid, pat_count += 1 and counter[i] += resp_data[i] for all i. When the accepted pattern makes pat_count == target, go to DRAIN. resp_valid is ignored in all other states.
- DRAIN: rd_valid = 1, rd_index starts at 0, rd_count = counter[rd_index]. rd_index advances on rd_valid && rd_ready. Acceptance at index NUM_OUT-1 (rd_last) goes to DONE.
- DONE: counters and pat_count hold their values. rd_valid = 0. A new start restarts the run.
- start in ACCUM or DRAIN is ignored. No abort exists except reset.
- Widths: pat_count cannot exceed target, so counters cannot overflow and need no saturation. All arithmetic is unsigned CNT_W.

## Timing
- Reset values: state IDLE, busy 0, done 0, rd_valid 0, rd_index 0, rd_count 0, rd_last 0, pat_count 0, all counters 0.
- Reset asserted mid-run, in any state, forces the reset values on the next edge. The partial run is discarded.
- start accepted at edge k: busy = 1 from cycle k+1.
- resp accepted at edge k: visible in pat_count and counters from cycle k+1.
- Final pattern accepted at edge k: rd_valid = 1 at cycle k+1 with rd_index 0, and the count includes that pattern. Zero-bubble.
- Target 0: DRAIN at k+1 with all counts 0.
- rd_valid is held with stable rd_index/rd_count until accepted.
- With rd_ready tied high, DRAIN lasts exactly NUM_OUT cycles.
- done rises the cycle after the rd_last acceptance.
- start together with resp_valid in DONE: the start is taken and the response is ignored.

## Structure
- Package stat_pkg: state enum (IDLE, ACCUM, DRAIN, DONE), NUM_OUT default, IDX_W derivation.
- Sub-module stat_bit_counter: one CNT_W counter with clear/enable/inc inputs, instanced NUM_OUT times via generate.
- Top holds the FSM, pattern counter, target register and readout mux.

## Test plan
- Reset, num_patterns=4, four responses 22'h000001, 22'h000003, 22'h200001, 22'h000000, rd_ready=1 -> counts: idx0=3, idx1=1, idx21=1, all others 0. rd_last with idx21. done afterwards. pat_count=4.
- num_patterns=0, start -> DRAIN on the next cycle, 22 words all count 0, done.
- num_patterns=3, resp_valid gaps between patterns, plus resp_valid asserted while IDLE -> only in-ACCUM responses counted. DRAIN starts the cycle after the 3rd accepted response.
- Readout with rd_ready toggled 1/0 -> rd_index/rd_count stable while stalled. Indices 0..21 each delivered exactly once.
- num_patterns=65535, resp_data all ones -> every count 65535 with no wrap. A second start in DONE clears all counts to 0.
- reset pulsed during ACCUM after 2 of 5 patterns -> all outputs at reset values. A fresh start of 1 pattern 22'h3FFFFF yields all counts 1.
